pd_rx_protocol: RTL and testbench

PD_RX_PROTOCOL -- requirements
Module: pd_rx_protocol

---
 rtl/pd_pkg.sv | 34 +++
 rtl/pd_msgid_table.sv | 51 +++++
 rtl/pd_rx_protocol.sv | 155 +++++++++++++++
 tb/tb_pd_rx_protocol.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared USB-PD protocol definitions: state encodings, message types, frame types
// and header field positions used by the receiver and transmitter.
package pd_pkg;

   typedef enum logic [5:0] {
      ST_IDLE         = 6'b000001,
      ST_CHECK_TYPE   = 6'b000010,
      ST_WAIT_GOODCRC = 6'b000100,
      ST_CHECK_ID     = 6'b001000,
      ST_STORE        = 6'b010000,
      ST_HARD_RESET   = 6'b100000
   } rxState_t;

   localparam logic [4:0] MSG_GOODCRC    = 5'h01;
   localparam logic [4:0] MSG_SOFT_RESET = 5'h0D;

   localparam logic [2:0] FRAME_SOP    = 3'd0;
   localparam logic [2:0] FRAME_SOP_P  = 3'd1;
   localparam logic [2:0] FRAME_SOP_PP = 3'd2;
   localparam int         NUM_FRAME_TYPES = 3;

   // Bit positions inside the 240-bit message: header high byte at 239:232, low byte at 231:224
   localparam int HDR_HI_POS   = 232;
   localparam int MSGTYPE_POS  = 224;
   localparam int MSGID_POS    = 233;
   localparam int NDO_POS      = 236;

   function automatic logic isControlMsg(input logic [4:0] msgType,
                                         input logic [2:0] ndo,
                                         input logic [4:0] target);
      return (msgType == target) && (ndo == 3'd0);
   endfunction

endpackage

// File: rtl/pd_msgid_table.sv
// Last accepted MessageID per frame type (SOP, SOP', SOP''), with valid flags used
// for duplicate detection.
module pd_msgid_table
   import pd_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] i_lookupType,
   output logic       o_idValid,
   output logic [2:0] o_storedId,
   input  logic       i_update,
   input  logic [1:0] i_updateType,
   input  logic [2:0] i_updateId,
   input  logic       i_clearAll,
   input  logic       i_clearOthers
);

   logic [NUM_FRAME_TYPES-1:0] r_valid;
   logic [2:0]                 r_storedId [NUM_FRAME_TYPES];

   // Clear-all beats an update; a Soft Reset update also invalidates the other entries
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_FRAME_TYPES; i++) r_storedId[i] <= 3'd0;
      end else if (i_clearAll) begin
         r_valid <= '0;
      end else if (i_update) begin
         for (int i = 0; i < NUM_FRAME_TYPES; i++) begin
            if (i_updateType == 2'(i)) begin
               r_valid[i]    <= 1'b1;
               r_storedId[i] <= i_updateId;
            end else if (i_clearOthers) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      o_idValid  = 1'b0;
      o_storedId = 3'd0;
      for (int i = 0; i < NUM_FRAME_TYPES; i++) begin
         if (i_lookupType == 2'(i)) begin
            o_idValid  = r_valid[i];
            o_storedId = r_storedId[i];
         end
      end
   end

endmodule

// File: rtl/pd_rx_protocol.sv
// USB-PD protocol-layer receiver: filters frames, answers with GoodCRC requests,
// drops duplicates by MessageID and raises sticky alerts.
module pd_rx_protocol
   import pd_pkg::*;
#(
   parameter int GOODCRC_TIMEOUT = 15
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [7:0]   RECEIVE_DETECT,
   input  logic         PhyMessageValid,
   input  logic [239:0] PHY_RX_DATA,
   input  logic [2:0]   PHY_RX_FRAME_TYPE,
   input  logic         PhyHardReset,
   input  logic         GoodCRCSent,
   input  logic [2:0]   ALERT_CLEAR,
   output logic         GoodCRCRequest,
   output logic [2:0]   GOODCRC_MESSAGE_ID,
   output logic [2:0]   GOODCRC_FRAME_TYPE,
   output logic         GoodCRCResponse,
   output logic [7:0]   RX_BUF_HEADER_BYTE_1,
   output logic [7:0]   RX_BUF_FRAME_TYPE,
   output logic [239:0] RECEIVE_DATA_OUTPUT,
   output logic [2:0]   RECEIVE_FRAME_TYPE,
   output logic         Alert_ReceivedMessage,
   output logic         Alert_ReceivedHardReset,
   output logic         Alert_RxOverflow
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(GOODCRC_TIMEOUT);

   rxState_t     r_state;
   logic [239:0] r_capData;
   logic [2:0]   r_capType;
   logic [7:0]   r_count;

   logic [4:0] w_msgType;
   logic [2:0] w_msgId;
   logic [2:0] w_ndo;
   logic       w_isGoodCrc;
   logic       w_isSoftReset;
   logic       w_frameAccept;
   logic       w_idValid;
   logic [2:0] w_storedId;
   logic       w_duplicate;
   logic       w_tableUpdate;
   logic [7:0] w_countNext;

   assign w_msgType     = r_capData[MSGTYPE_POS +: 5];
   assign w_msgId       = r_capData[MSGID_POS +: 3];
   assign w_ndo         = r_capData[NDO_POS +: 3];
   assign w_isGoodCrc   = isControlMsg(w_msgType, w_ndo, MSG_GOODCRC);
   assign w_isSoftReset = isControlMsg(w_msgType, w_ndo, MSG_SOFT_RESET);
   assign w_frameAccept = PhyMessageValid && (PHY_RX_FRAME_TYPE <= FRAME_SOP_PP)
                          && RECEIVE_DETECT[PHY_RX_FRAME_TYPE];
   assign w_duplicate   = w_idValid && (w_storedId == w_msgId) && !w_isSoftReset;
   assign w_tableUpdate = (r_state == ST_CHECK_ID) && !w_duplicate && !PhyHardReset;
   assign w_countNext   = r_count + 8'd1;

   pd_msgid_table u_msgIdTable (
      .Clock         (Clock),
      .Reset         (Reset),
      .i_lookupType  (r_capType[1:0]),
      .o_idValid     (w_idValid),
      .o_storedId    (w_storedId),
      .i_update      (w_tableUpdate),
      .i_updateType  (r_capType[1:0]),
      .i_updateId    (w_msgId),
      .i_clearAll    (PhyHardReset),
      .i_clearOthers (w_tableUpdate && w_isSoftReset)
   );

   // Outputs are registered on entry to the state that owns them, which keeps the
   // strobe-to-request and sent-to-alert latencies at two cycles.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state                 <= ST_IDLE;
         r_capData               <= '0;
         r_capType               <= 3'd0;
         r_count                 <= 8'd0;
         GoodCRCRequest          <= 1'b0;
         GOODCRC_MESSAGE_ID      <= 3'd0;
         GOODCRC_FRAME_TYPE      <= 3'd0;
         GoodCRCResponse         <= 1'b0;
         RX_BUF_HEADER_BYTE_1    <= 8'd0;
         RX_BUF_FRAME_TYPE       <= 8'd0;
         RECEIVE_DATA_OUTPUT     <= '0;
         RECEIVE_FRAME_TYPE      <= 3'd0;
         Alert_ReceivedMessage   <= 1'b0;
         Alert_ReceivedHardReset <= 1'b0;
         Alert_RxOverflow        <= 1'b0;
      end else begin
         GoodCRCResponse         <= 1'b0;
         Alert_ReceivedMessage   <= Alert_ReceivedMessage & ~ALERT_CLEAR[0];
         Alert_ReceivedHardReset <= Alert_ReceivedHardReset & ~ALERT_CLEAR[1];
         Alert_RxOverflow        <= Alert_RxOverflow & ~ALERT_CLEAR[2];
         if (PhyHardReset) begin
            r_state                 <= ST_HARD_RESET;
            GoodCRCRequest          <= 1'b0;
            Alert_ReceivedHardReset <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_frameAccept) begin
                     r_capData <= PHY_RX_DATA;
                     r_capType <= PHY_RX_FRAME_TYPE;
                     r_state   <= ST_CHECK_TYPE;
                  end
               end
               ST_CHECK_TYPE: begin
                  if (w_isGoodCrc) begin
                     GoodCRCResponse      <= 1'b1;
                     RX_BUF_HEADER_BYTE_1 <= r_capData[HDR_HI_POS +: 8];
                     RX_BUF_FRAME_TYPE    <= {5'd0, r_capType};
                     r_state              <= ST_IDLE;
                  end else if (Alert_ReceivedMessage) begin
                     Alert_RxOverflow <= 1'b1;
                     r_state          <= ST_IDLE;
                  end else begin
                     r_count            <= 8'd0;
                     GoodCRCRequest     <= 1'b1;
                     GOODCRC_MESSAGE_ID <= w_msgId;
                     GOODCRC_FRAME_TYPE <= r_capType;
                     r_state            <= ST_WAIT_GOODCRC;
                  end
               end
               ST_WAIT_GOODCRC: begin
                  r_count <= w_countNext;
                  if (GoodCRCSent) begin
                     GoodCRCRequest <= 1'b0;
                     r_state        <= ST_CHECK_ID;
                  end else if (w_countNext == TIMEOUT_LIMIT) begin
                     GoodCRCRequest <= 1'b0;
                     r_state        <= ST_IDLE;
                  end
               end
               ST_CHECK_ID: begin
                  if (w_duplicate) begin
                     r_state <= ST_IDLE;
                  end else begin
                     RECEIVE_DATA_OUTPUT   <= r_capData;
                     RECEIVE_FRAME_TYPE    <= r_capType;
                     Alert_ReceivedMessage <= 1'b1;
                     r_state               <= ST_STORE;
                  end
               end
               ST_STORE:      r_state <= ST_IDLE;
               ST_HARD_RESET: r_state <= ST_IDLE;
               default:       r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pd_rx_protocol.sv
// Directed self-checking bench for pd_rx_protocol: reception, duplicates, GoodCRC
// reception, overflow, GoodCRC timeout and hard reset.
module tb_pd_rx_protocol;

   logic         Clock;
   logic         Reset;
   logic [7:0]   RECEIVE_DETECT;
   logic         PhyMessageValid;
   logic [239:0] PHY_RX_DATA;
   logic [2:0]   PHY_RX_FRAME_TYPE;
   logic         PhyHardReset;
   logic         GoodCRCSent;
   logic [2:0]   ALERT_CLEAR;
   logic         GoodCRCRequest;
   logic [2:0]   GOODCRC_MESSAGE_ID;
   logic [2:0]   GOODCRC_FRAME_TYPE;
   logic         GoodCRCResponse;
   logic [7:0]   RX_BUF_HEADER_BYTE_1;
   logic [7:0]   RX_BUF_FRAME_TYPE;
   logic [239:0] RECEIVE_DATA_OUTPUT;
   logic [2:0]   RECEIVE_FRAME_TYPE;
   logic         Alert_ReceivedMessage;
   logic         Alert_ReceivedHardReset;
   logic         Alert_RxOverflow;

   int testsRun    = 0;
   int testsFailed = 0;

   // Headers: high byte {0, NDO[2:0], ID[2:0], 0}, low byte holds MsgType
   localparam logic [239:0] MSG_A = {8'h16, 8'h02, 224'h0123_4567_89AB_CDEF}; // ID3 NDO1 type2
   localparam logic [239:0] MSG_B = {8'h18, 8'h03, 224'hCAFE_F00D};           // ID4 NDO1 type3
   localparam logic [239:0] MSG_C = {8'h1A, 8'h02, 224'h5555_AAAA};           // ID5 NDO1 type2
   localparam logic [239:0] GCRC  = {8'h06, 8'h01, 224'h0};                   // GoodCRC ID3

   pd_rx_protocol #(.GOODCRC_TIMEOUT(15)) dut (
      .Clock                   (Clock),
      .Reset                   (Reset),
      .RECEIVE_DETECT          (RECEIVE_DETECT),
      .PhyMessageValid         (PhyMessageValid),
      .PHY_RX_DATA             (PHY_RX_DATA),
      .PHY_RX_FRAME_TYPE       (PHY_RX_FRAME_TYPE),
      .PhyHardReset            (PhyHardReset),
      .GoodCRCSent             (GoodCRCSent),
      .ALERT_CLEAR             (ALERT_CLEAR),
      .GoodCRCRequest          (GoodCRCRequest),
      .GOODCRC_MESSAGE_ID      (GOODCRC_MESSAGE_ID),
      .GOODCRC_FRAME_TYPE      (GOODCRC_FRAME_TYPE),
      .GoodCRCResponse         (GoodCRCResponse),
      .RX_BUF_HEADER_BYTE_1    (RX_BUF_HEADER_BYTE_1),
      .RX_BUF_FRAME_TYPE       (RX_BUF_FRAME_TYPE),
      .RECEIVE_DATA_OUTPUT     (RECEIVE_DATA_OUTPUT),
      .RECEIVE_FRAME_TYPE      (RECEIVE_FRAME_TYPE),
      .Alert_ReceivedMessage   (Alert_ReceivedMessage),
      .Alert_ReceivedHardReset (Alert_ReceivedHardReset),
      .Alert_RxOverflow        (Alert_RxOverflow)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [239:0] observed,
                              input logic [239:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Presents one message strobe; on return the DUT has sampled it
   task automatic applyStimulus(input logic [239:0] data, input logic [2:0] frameType);
      PHY_RX_DATA       = data;
      PHY_RX_FRAME_TYPE = frameType;
      PhyMessageValid   = 1'b1;
      tick(1);
      PhyMessageValid   = 1'b0;
   endtask

   task automatic sendGoodCrc();
      GoodCRCSent = 1'b1;
      tick(1);
      GoodCRCSent = 1'b0;
   endtask

   task automatic clearAlerts(input logic [2:0] mask);
      ALERT_CLEAR = mask;
      tick(1);
      ALERT_CLEAR = 3'b000;
   endtask

   initial begin
      Reset             = 1'b1;
      RECEIVE_DETECT    = 8'h01;
      PhyMessageValid   = 1'b0;
      PHY_RX_DATA       = '0;
      PHY_RX_FRAME_TYPE = 3'd0;
      PhyHardReset      = 1'b0;
      GoodCRCSent       = 1'b0;
      ALERT_CLEAR       = 3'b000;
      tick(3);
      checkBit("rst_req", GoodCRCRequest, 1'b0);
      checkBit("rst_alertMsg", Alert_ReceivedMessage, 1'b0);
      checkBit("rst_alertHr", Alert_ReceivedHardReset, 1'b0);
      checkBit("rst_alertOvf", Alert_RxOverflow, 1'b0);
      checkOutput("rst_data", RECEIVE_DATA_OUTPUT, 240'd0);
      Reset = 1'b0;
      tick(1);

      // SOP' is not enabled, so the strobe is ignored
      applyStimulus(MSG_C, 3'd1);
      tick(1);
      checkBit("filter_req", GoodCRCRequest, 1'b0);

      applyStimulus(MSG_A, 3'd0);
      checkBit("lat_checkType", GoodCRCRequest, 1'b0);
      tick(1);
      checkBit("lat_req", GoodCRCRequest, 1'b1);
      checkOutput("gc_msgId", 240'(GOODCRC_MESSAGE_ID), 240'(3));
      checkOutput("gc_frame", 240'(GOODCRC_FRAME_TYPE), 240'(0));
      tick(3);
      sendGoodCrc();
      checkBit("chkid_alert", Alert_ReceivedMessage, 1'b0);
      checkBit("chkid_req", GoodCRCRequest, 1'b0);
      tick(1);
      checkBit("store_alert", Alert_ReceivedMessage, 1'b1);
      checkOutput("store_data", RECEIVE_DATA_OUTPUT, MSG_A);
      checkOutput("store_frame", 240'(RECEIVE_FRAME_TYPE), 240'(0));
      tick(1);

      clearAlerts(3'b001);
      checkBit("clr_alert", Alert_ReceivedMessage, 1'b0);
      applyStimulus(MSG_A, 3'd0);
      tick(1);
      checkBit("dup_req", GoodCRCRequest, 1'b1);
      sendGoodCrc();
      tick(1);
      checkBit("dup_alert", Alert_ReceivedMessage, 1'b0);
      tick(1);
      checkBit("dup_alert2", Alert_ReceivedMessage, 1'b0);

      applyStimulus(GCRC, 3'd0);
      checkBit("gcrx_resp0", GoodCRCResponse, 1'b0);
      tick(1);
      checkBit("gcrx_resp", GoodCRCResponse, 1'b1);
      checkOutput("gcrx_hdr", 240'(RX_BUF_HEADER_BYTE_1), 240'(8'h06));
      checkOutput("gcrx_frame", 240'(RX_BUF_FRAME_TYPE), 240'(0));
      checkBit("gcrx_req", GoodCRCRequest, 1'b0);
      checkOutput("gcrx_keep", RECEIVE_DATA_OUTPUT, MSG_A);
      tick(1);
      checkBit("gcrx_pulse", GoodCRCResponse, 1'b0);
      checkBit("gcrx_req2", GoodCRCRequest, 1'b0);

      applyStimulus(MSG_B, 3'd0);
      tick(1);
      sendGoodCrc();
      tick(1);
      checkBit("b_alert", Alert_ReceivedMessage, 1'b1);
      tick(1);
      applyStimulus(MSG_C, 3'd0);
      tick(1);
      checkBit("ovf_alert", Alert_RxOverflow, 1'b1);
      checkBit("ovf_req", GoodCRCRequest, 1'b0);
      checkOutput("ovf_keep", RECEIVE_DATA_OUTPUT, MSG_B);
      clearAlerts(3'b111);
      checkBit("ovf_clr", Alert_RxOverflow, 1'b0);
      checkBit("msg_clr", Alert_ReceivedMessage, 1'b0);

      // GoodCRCSent withheld: request stays up for exactly 15 cycles
      applyStimulus(MSG_A, 3'd0);
      tick(1);
      checkBit("to_req0", GoodCRCRequest, 1'b1);
      tick(14);
      checkBit("to_req14", GoodCRCRequest, 1'b1);
      tick(1);
      checkBit("to_drop", GoodCRCRequest, 1'b0);
      checkBit("to_alert", Alert_ReceivedMessage, 1'b0);
      applyStimulus(MSG_A, 3'd0);
      tick(1);
      checkBit("re_req", GoodCRCRequest, 1'b1);
      sendGoodCrc();
      tick(1);
      checkBit("re_alert", Alert_ReceivedMessage, 1'b1);
      checkOutput("re_data", RECEIVE_DATA_OUTPUT, MSG_A);
      tick(1);
      clearAlerts(3'b001);

      // GoodCRCSent on the final timeout cycle still completes the message
      applyStimulus(MSG_B, 3'd0);
      tick(15);
      sendGoodCrc();
      checkBit("last_req", GoodCRCRequest, 1'b0);
      tick(1);
      checkBit("last_alert", Alert_ReceivedMessage, 1'b1);
      checkOutput("last_data", RECEIVE_DATA_OUTPUT, MSG_B);
      tick(1);
      clearAlerts(3'b001);

      applyStimulus(MSG_B, 3'd0);
      tick(1);
      checkBit("hr_req0", GoodCRCRequest, 1'b1);
      PhyHardReset = 1'b1;
      tick(1);
      PhyHardReset = 1'b0;
      checkBit("hr_alert", Alert_ReceivedHardReset, 1'b1);
      checkBit("hr_req", GoodCRCRequest, 1'b0);
      tick(1);
      applyStimulus(MSG_B, 3'd0);
      tick(1);
      checkBit("hr_req1", GoodCRCRequest, 1'b1);
      sendGoodCrc();
      tick(1);
      checkBit("hr_store", Alert_ReceivedMessage, 1'b1);
      tick(1);

      // Set and clear of the same alert in one cycle leaves it set
      ALERT_CLEAR  = 3'b010;
      PhyHardReset = 1'b1;
      tick(1);
      PhyHardReset = 1'b0;
      ALERT_CLEAR  = 3'b000;
      checkBit("col_hr", Alert_ReceivedHardReset, 1'b1);
      tick(1);
      clearAlerts(3'b010);
      checkBit("clr_hr", Alert_ReceivedHardReset, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

endmodule
